// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// Build option: REGFILE_CLEAR_EN enables the post-reset clear sequence.
package regfile_pkg;

    localparam int RF_DATA_WIDTH  = 32;
    localparam int RF_WORDS       = 32;
    localparam int RF_SELECT_SIZE = 5;

    typedef logic [RF_SELECT_SIZE-1:0] reg_sel_t;
    typedef logic [RF_DATA_WIDTH-1:0]  reg_data_t;

    typedef enum logic {
        CLEAR,
        IDLE
    } arb_state_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin grant: first valid index after the last winner.
// The pointer only moves when the winner's transfer completes.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o
);

    localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [LW-1:0] last_q;
    logic [LW-1:0] last_d;
    logic          found;

    always_comb begin
        grant_o = '0;
        last_d  = last_q;
        found   = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && valid_i[LW'((int'(last_q) + i) % NUM_REQ)]) begin
                found = 1'b1;
                grant_o[LW'((int'(last_q) + i) % NUM_REQ)] = 1'b1;
                last_d = LW'((int'(last_q) + i) % NUM_REQ);
            end
        end
    end

    // Reset to the top index so requester 0 is searched first.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            last_q <= LW'(NUM_REQ - 1);
        end else if (advance_i) begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port among NUM_REQ requesters.
// Define REGFILE_CLEAR_EN to zero x1..x(WORDS-1) after every reset.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH  = RF_DATA_WIDTH,
    parameter int WORDS       = RF_WORDS,
    parameter int SELECT_SIZE = RF_SELECT_SIZE,
    parameter int NUM_REQ     = 2
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*SELECT_SIZE-1:0] req_dst_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_i,
    output logic                           reg_we_o,
    output logic [SELECT_SIZE-1:0]         reg_dst_o,
    output logic [DATA_WIDTH-1:0]          data_o,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic                           busy_o
);

    logic                   we_q;
    logic [SELECT_SIZE-1:0] dst_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [NUM_REQ-1:0]     grant_q;
    logic [NUM_REQ-1:0]     arb_grant;
    logic [SELECT_SIZE-1:0] win_dst;
    logic [DATA_WIDTH-1:0]  win_data;
    logic [SELECT_SIZE-1:0] clr_sel;
    logic                   xfer;

`ifdef REGFILE_CLEAR_EN
    arb_state_t             state_q;
    logic [SELECT_SIZE-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= CLEAR;
            cnt_q   <= SELECT_SIZE'(1);
        end else if (state_q == CLEAR) begin
            if (cnt_q == SELECT_SIZE'(WORDS - 1)) begin
                state_q <= IDLE;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign busy_o  = (state_q == CLEAR);
    assign clr_sel = cnt_q;
`else
    assign busy_o  = 1'b0;
    assign clr_sel = '0;
`endif

    assign req_ready_o = (reset_i && !busy_o) ? arb_grant : '0;
    assign xfer        = |req_ready_o;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .valid_i  (req_valid_i),
        .advance_i(xfer),
        .grant_o  (arb_grant)
    );

    always_comb begin
        win_dst  = '0;
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_ready_o[k]) begin
                win_dst  = req_dst_i[k*SELECT_SIZE +: SELECT_SIZE];
                win_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Writes to x0 still win the port but never pulse the enable.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            we_q    <= 1'b1;
            dst_q   <= '0;
            data_q  <= '0;
            grant_q <= '0;
        end else if (busy_o) begin
            we_q    <= 1'b0;
            dst_q   <= clr_sel;
            data_q  <= '0;
            grant_q <= '0;
        end else if (xfer) begin
            we_q    <= (int'(win_dst) == REG_ZERO);
            dst_q   <= win_dst;
            data_q  <= win_data;
            grant_q <= req_ready_o;
        end else begin
            we_q    <= 1'b1;
            grant_q <= '0;
        end
    end

    assign reg_we_o  = we_q;
    assign reg_dst_o = dst_q;
    assign data_o    = data_q;
    assign grant_o   = grant_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter (NUM_REQ=2, 32x32).
// Covers both builds; clear-sequence checks only with REGFILE_CLEAR_EN.
module tb_regfile_write_arbiter;

    localparam int DW = 32;
    localparam int NW = 32;
    localparam int SS = 5;
    localparam int NR = 2;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [NR-1:0]   req_valid_i;
    logic [NR-1:0]   req_ready_o;
    logic [NR*SS-1:0] req_dst_i;
    logic [NR*DW-1:0] req_data_i;
    logic            reg_we_o;
    logic [SS-1:0]   reg_dst_o;
    logic [DW-1:0]   data_o;
    logic [NR-1:0]   grant_o;
    logic            busy_o;

    regfile_write_arbiter #(
        .DATA_WIDTH (DW),
        .WORDS      (NW),
        .SELECT_SIZE(SS),
        .NUM_REQ    (NR)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_dst_i  (req_dst_i),
        .req_data_i (req_data_i),
        .reg_we_o   (reg_we_o),
        .reg_dst_o  (reg_dst_o),
        .data_o     (data_o),
        .grant_o    (grant_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic          we;
        logic [SS-1:0] dst;
        logic [DW-1:0] data;
        logic [NR-1:0] grant;
    } exp_t;

    exp_t          q[$];
    int            n_chk  = 0;
    int            n_fail = 0;
    int            last_w = NR - 1;
    logic          mon_off = 1'b1;
    logic [DW-1:0] rf[NW];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stand-in register file, written on the negedge like the real one.
    initial for (int i = 0; i < NW; i++) rf[i] = '0;
    always @(negedge clk_i) begin
        if (!reg_we_o) rf[reg_dst_o] <= data_o;
    end

    // Monitor: any write-port activity must match the oldest expectation.
    always @(negedge clk_i) begin
        exp_t e;
        if (!mon_off && (reg_we_o == 1'b0 || grant_o != '0)) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL port_unexpected: we=%b dst=%0d data=%h grant=%b",
                         reg_we_o, reg_dst_o, data_o, grant_o);
            end else begin
                e = q.pop_front();
                if (reg_we_o !== e.we || grant_o !== e.grant ||
                    (!e.we && (reg_dst_o !== e.dst || data_o !== e.data))) begin
                    n_fail++;
                    $display("FAIL port_write: got we=%b dst=%0d data=%h grant=%b expected we=%b dst=%0d data=%h grant=%b",
                             reg_we_o, reg_dst_o, data_o, grant_o,
                             e.we, e.dst, e.data, e.grant);
                end
            end
        end
    end

    // One cycle of stimulus; reference picks the winner by plain rotation.
    task automatic cycle(input logic rst_n, input logic [NR-1:0] v,
                         input logic [SS-1:0] d0, input logic [SS-1:0] d1,
                         input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                         output int win);
        logic [NR-1:0] exp_rdy;
        logic [SS-1:0] dd[NR];
        logic [DW-1:0] xx[NR];
        exp_t          e;
        dd[0] = d0; dd[1] = d1;
        xx[0] = x0; xx[1] = x1;
        reset_i     = rst_n;
        req_valid_i = v;
        req_dst_i   = {d1, d0};
        req_data_i  = {x1, x0};
        #1;
        win     = -1;
        exp_rdy = '0;
        if (rst_n) begin
            for (int i = 1; i <= NR; i++) begin
                if (win < 0 && v[(last_w + i) % NR]) win = (last_w + i) % NR;
            end
        end
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("ready", 64'(req_ready_o), 64'(exp_rdy));
        if (!rst_n) begin
            last_w = NR - 1;
        end else if (win >= 0) begin
            last_w  = win;
            e.we    = (dd[win] == '0);
            e.dst   = dd[win];
            e.data  = xx[win];
            e.grant = exp_rdy;
            q.push_back(e);
        end
        @(negedge clk_i);
    endtask

    task automatic clear_seq(input int stop_at);
        mon_off = 1'b1;
        reset_i = 1'b1;
        req_valid_i = 2'b11;
        for (int k = 1; k < NW; k++) begin
            @(negedge clk_i);
            chk("clr_we", 64'(reg_we_o), 64'(0));
            chk("clr_dst", 64'(reg_dst_o), 64'(k));
            chk("clr_data", 64'(data_o), 64'(0));
            chk("clr_busy", 64'(busy_o), 64'(k < NW - 1));
            chk("clr_ready", 64'(req_ready_o), 64'(0));
            if (k == stop_at) return;
        end
        #1 mon_off = 1'b0;
    endtask

    initial begin
        int            w;
        logic          pend[NR];
        logic [SS-1:0] pd[NR];
        logic [DW-1:0] px[NR];
        logic [NR-1:0] v;

        reset_i     = 1'b0;
        req_valid_i = 2'b11;
        req_dst_i   = {5'd7, 5'd9};
        req_data_i  = {32'hAAAA5555, 32'h5555AAAA};
        repeat (3) @(negedge clk_i);
        chk("rst_we", 64'(reg_we_o), 64'(1));
        chk("rst_dst", 64'(reg_dst_o), 64'(0));
        chk("rst_data", 64'(data_o), 64'(0));
        chk("rst_grant", 64'(grant_o), 64'(0));
        chk("rst_ready", 64'(req_ready_o), 64'(0));
`ifdef REGFILE_CLEAR_EN
        chk("rst_busy", 64'(busy_o), 64'(1));
        clear_seq(0);
`else
        chk("rst_busy", 64'(busy_o), 64'(0));
        mon_off = 1'b0;
`endif

        // Single request from requester 1, possibly the very first cycle.
        cycle(1'b1, 2'b10, 5'd0, 5'd5, 32'h0, 32'hBEEFDEAD, w);
        cycle(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, w);
        chk("rf_x5", 64'(rf[5]), 64'(32'hBEEFDEAD));

        // Both continuously valid: grants alternate starting at 0.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 2'b11, 5'd3, 5'd4, 32'h300 + i, 32'h400 + i, w);
            chk("alt_win", 64'(w), 64'(i % 2));
        end

        // x0 write: accepted and granted, enable stays high.
        cycle(1'b1, 2'b01, 5'd0, 5'd0, 32'h12345678, 32'h0, w);
        cycle(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, w);
        chk("rf_x0", 64'(rf[0]), 64'(0));

        // Requester 0 loses, withdraws, then wins the next contention.
        cycle(1'b1, 2'b11, 5'd8, 5'd9, 32'h8, 32'h9, w);
        chk("wd_win1", 64'(w), 64'(1));
        cycle(1'b1, 2'b00, 5'd8, 5'd9, 32'h8, 32'h9, w);
        cycle(1'b1, 2'b11, 5'd10, 5'd11, 32'hA, 32'hB, w);
        chk("wd_win0", 64'(w), 64'(0));

        // Reset the cycle after a handshake: request is dropped.
        cycle(1'b1, 2'b10, 5'd0, 5'd12, 32'h0, 32'hC, w);
        cycle(1'b0, 2'b11, 5'd13, 5'd14, 32'hD, 32'hE, w);
        chk("rst_mid_we", 64'(reg_we_o), 64'(1));
`ifdef REGFILE_CLEAR_EN
        clear_seq(10);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("rst_clr_we", 64'(reg_we_o), 64'(1));
        last_w = NR - 1;
        clear_seq(0);
`endif
        cycle(1'b1, 2'b11, 5'd15, 5'd16, 32'hF, 32'h10, w);
        chk("post_rst_win", 64'(w), 64'(0));

        // Random traffic with hold-until-accepted and occasional withdrawal.
        for (int r = 0; r < NR; r++) begin
            pend[r] = 1'b0;
            pd[r]   = '0;
            px[r]   = '0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < NR; r++) begin
                if (!pend[r]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        pend[r] = 1'b1;
                        pd[r] = ($urandom_range(7, 0) == 0) ? 5'd0 : SS'($urandom);
                        px[r] = $urandom;
                    end
                end else if ($urandom_range(9, 0) == 0) begin
                    pend[r] = 1'b0;
                end
            end
            v = {pend[1], pend[0]};
            cycle(1'b1, v, pd[0], pd[1], px[0], px[1], w);
            if (w >= 0) pend[w] = 1'b0;
        end

        cycle(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, w);
        @(negedge clk_i);
        chk("queue_empty", 64'(q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
